// File: rtl/cmap_wb_sequencer_if.sv
// Bus bundle between the write-back sequencer, the cmap buffer, the output-map
// BRAM and the tile controller. The sequencer is the master side.
interface cmap_wb_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int DW    = 16,
  parameter int AW    = 10
);
  // tile controller handshake
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [WIDTH*DW-1:0]   psum_in;
  logic                  busy;
  logic                  tile_done;
  // cmap buffer
  logic                  load;
  logic [4:0]            done;
  logic                  cmap_out;
  // output-map BRAM
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [DW-1:0]         rd_data;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;

  modport master (
    input  start, base_addr, psum_in, cmap_out, rd_data,
    output load, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, tile_done
  );

  modport slave (
    output start, base_addr, psum_in, cmap_out, rd_data,
    input  load, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, tile_done
  );
endinterface

// File: rtl/cmap_wb_sequencer.sv
// Write-back sequencer behind the MM2IM channel-map buffer. For each tile it
// snapshots the cmap, walks the column selector 1..WIDTH and read-modify-writes
// the partial sum of every flagged column into the output-map BRAM.
module cmap_wb_sequencer #(
  parameter int WIDTH = 16,
  parameter int DW    = 16,
  parameter int AW    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  cmap_wb_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ACC   = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [4:0]    LAST_COL = 5'(WIDTH);
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [4:0]          done_q, done_d;
  logic [AW-1:0]       col_addr_q, col_addr_d;   // base + (done-1), wraps at 2^AW
  logic [WIDTH*DW-1:0] psum_q, psum_d;
  logic                busy_q, busy_d;
  logic                tile_done_q, tile_done_d;

  logic [4:0]          col_idx_s;
  logic [DW-1:0]       psum_col_s;
  logic                load_s;
  logic                rd_en_s;
  logic                wr_en_s;
  logic [DW-1:0]       wr_data_s;

  assign col_idx_s = done_q - 5'd1;

  // State and datapath registers; synchronous reset aborts any tile in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_q      <= 5'd0;
      col_addr_q  <= {AW{1'b0}};
      psum_q      <= {(WIDTH*DW){1'b0}};
      busy_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      col_addr_q  <= col_addr_d;
      psum_q      <= psum_d;
      busy_q      <= busy_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Next-state, column selector and snapshot capture.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    col_addr_d = col_addr_q;
    psum_d     = psum_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_CHECK;
          done_d     = 5'd1;
          col_addr_d = bus.base_addr;
          psum_d     = bus.psum_in;
        end else begin
          done_d     = 5'd0;
        end
      end
      ST_CHECK: begin
        if (bus.cmap_out) begin
          state_d = ST_ACC;
        end else if (done_q == LAST_COL) begin
          state_d = ST_FIN;
        end else begin
          done_d     = done_q + 5'd1;
          col_addr_d = col_addr_q + ADDR_ONE;
        end
      end
      ST_ACC: begin
        if (done_q == LAST_COL) begin
          state_d = ST_FIN;
        end else begin
          state_d    = ST_CHECK;
          done_d     = done_q + 5'd1;
          col_addr_d = col_addr_q + ADDR_ONE;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 5'd0;
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 5'd0;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    tile_done_d = (state_d == ST_FIN);
  end

  // Select the partial sum of the current column from the snapshot.
  always_comb begin
    psum_col_s = {DW{1'b0}};
    for (int c = 0; c < WIDTH; c++) begin
      psum_col_s = (col_idx_s == 5'(c)) ? psum_q[c*DW +: DW] : psum_col_s;
    end
  end

  // Strobes decoded from state; reset masks them so an abort takes effect at once.
  always_comb begin
    load_s    = 1'b0;
    rd_en_s   = 1'b0;
    wr_en_s   = 1'b0;
    wr_data_s = {DW{1'b0}};
    if (rst) begin
      load_s  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  load_s  = bus.start;
        ST_CHECK: rd_en_s = bus.cmap_out;
        ST_ACC: begin
          wr_en_s   = 1'b1;
          wr_data_s = bus.rd_data + psum_col_s;
        end
        ST_FIN:   load_s  = 1'b0;
        default:  load_s  = 1'b0;
      endcase
    end
  end

  assign bus.load      = load_s;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_s;
  assign bus.rd_addr   = col_addr_q;
  assign bus.wr_en     = wr_en_s;
  assign bus.wr_addr   = col_addr_q;
  assign bus.wr_data   = wr_data_s;
  assign bus.busy      = busy_q;
  assign bus.tile_done = tile_done_q;

endmodule

// File: tb/tb_cmap_wb_sequencer.sv
// Self-checking bench for cmap_wb_sequencer: behavioural cmap buffer and BRAM,
// expected reads/writes queued at tile setup and compared as the DUT issues them.
module tb_cmap_wb_sequencer;
  localparam int WIDTH = 16;
  localparam int DW    = 16;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmap_wb_sequencer_if #(.WIDTH(WIDTH), .DW(DW), .AW(AW)) bus ();
  cmap_wb_sequencer #(.WIDTH(WIDTH), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0]       mem [0:(1<<AW)-1];
  logic                pl_en = 1'b0;
  logic [AW-1:0]       pl_addr = '0;
  logic [DW-1:0]       pl_data = '0;
  logic [WIDTH-1:0]    cmap_src = '0;
  logic [WIDTH-1:0]    snap = '0;
  int                  cyc = 0;
  int                  n_checks = 0;
  int                  n_errors = 0;
  int                  load_cnt = 0;
  logic [4:0]          prev_done = 5'd0;
  logic [AW-1:0]       rd_q[$];
  logic [AW-1:0]       wa_q[$];
  logic [DW-1:0]       wd_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // cycle counter, BRAM (1-cycle read latency) and cmap buffer snapshot
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (bus.load) snap <= cmap_src;
  end

  assign bus.cmap_out = (bus.done != 5'd0 && bus.done <= 5'(WIDTH)) ? snap[4'(bus.done - 5'd1)] : 1'b0;

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.load === 1'b1) load_cnt++;
    if (bus.rd_en === 1'b1) begin
      if (rd_q.size() == 0) check_val("rd_unexpected", 32'(bus.rd_en), 32'd0);
      else check_val("rd_addr", 32'(bus.rd_addr), 32'(rd_q.pop_front()));
    end
    if (bus.wr_en === 1'b1) begin
      check_val("rd_wr_excl", 32'(bus.rd_en), 32'd0);
      if (wa_q.size() == 0) check_val("wr_unexpected", 32'(bus.wr_en), 32'd0);
      else begin
        check_val("wr_addr", 32'(bus.wr_addr), 32'(wa_q.pop_front()));
        check_val("wr_data", 32'(bus.wr_data), 32'(wd_q.pop_front()));
      end
    end
    if (bus.done !== prev_done && !$isunknown(bus.done)) begin
      check_val("done_range", 32'(bus.done <= 5'(WIDTH)), 32'd1);
      if (bus.done != 5'd0) check_val("done_step", 32'(bus.done), 32'(prev_done + 5'd1));
      prev_done = bus.done;
    end
  end

  task automatic preload(input logic [AW-1:0] base, input logic [DW-1:0] val);
    for (int c = 0; c < WIDTH; c++) begin
      @(posedge clk); #1;
      pl_en   = 1'b1;
      pl_addr = base + c[AW-1:0];
      pl_data = val;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic expect_tile(input logic [WIDTH-1:0] cmap, input logic [AW-1:0] base,
                             input logic [WIDTH*DW-1:0] pv, input logic [DW-1:0] val,
                             output int lat);
    int n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    n = 0;
    for (int c = 0; c < WIDTH; c++) begin
      if (cmap[c]) begin
        a = base + c[AW-1:0];
        d = val + pv[c*DW +: DW];
        rd_q.push_back(a);
        wa_q.push_back(a);
        wd_q.push_back(d);
        n++;
      end
    end
    lat           = WIDTH + n + 1;
    cmap_src      = cmap;
    bus.base_addr = base;
    bus.psum_in   = pv;
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk); #1;
    bus.start = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int sc, input int lat, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.tile_done === 1'b1) seen = 1'b1;
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    else check_val({tag, "_latency"}, 32'(cyc - sc), 32'(lat));
    check_val({tag, "_sb_left"}, 32'(rd_q.size() + wa_q.size()), 32'd0);
    @(negedge clk);
    check_val({tag, "_pulse"}, 32'(bus.tile_done), 32'd0);
    check_val({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  logic [WIDTH*DW-1:0] pv;
  int lat, sc, sc2, lc0;

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.psum_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check_val("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("rst_tile_done", 32'(bus.tile_done), 32'd0);
    check_val("rst_load", 32'(bus.load), 32'd0);
    check_val("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    #1 rst = 1'b0;

    // 1: empty cmap, every column skipped in one cycle
    pv = '0;
    for (int c = 0; c < WIDTH; c++) pv[c*DW +: DW] = 16'(c + 1);
    expect_tile(16'h0000, 10'h000, pv, 16'h0000, lat);
    lc0 = load_cnt;
    pulse_start(sc);
    @(negedge clk);
    check_val("t1_busy", 32'(bus.busy), 32'd1);
    check_val("t1_load", 32'(load_cnt), 32'(lc0 + 1));
    wait_done(sc, lat, "t1");

    // 2: full cmap, psum[c]=c+1 on top of 10
    preload(10'h100, 16'd10);
    expect_tile(16'hFFFF, 10'h100, pv, 16'd10, lat);
    pulse_start(sc);
    wait_done(sc, lat, "t2");

    // 3: first and last column, address wraps past 0x3FF
    for (int c = 0; c < WIDTH; c++) pv[c*DW +: DW] = 16'(16'h1000 + c);
    preload(10'h3FF, 16'd7);
    expect_tile(16'h8001, 10'h3FF, pv, 16'd7, lat);
    pulse_start(sc);
    wait_done(sc, lat, "t3");

    // 4: sum wraps modulo 2^DW
    pv = '0;
    pv[DW-1:0] = 16'h0020;
    preload(10'h050, 16'hFFF0);
    expect_tile(16'h0001, 10'h050, pv, 16'hFFF0, lat);
    pulse_start(sc);
    wait_done(sc, lat, "t4");

    // 5: reset while accumulating column 5, then a fresh tile
    for (int c = 0; c < WIDTH; c++) pv[c*DW +: DW] = 16'(c + 1);
    preload(10'h040, 16'd3);
    expect_tile(16'hFFFF, 10'h040, pv, 16'd3, lat);
    pulse_start(sc);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (bus.wr_en === 1'b1 && bus.done == 5'd6) hit = 1'b1;
      end
      check_val("t5_reach_col5", 32'(hit), 32'd1);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check_val("t5_done", 32'(bus.done), 32'd0);
    check_val("t5_busy", 32'(bus.busy), 32'd0);
    check_val("t5_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("t5_rd_en", 32'(bus.rd_en), 32'd0);
    #1 rst = 1'b0;
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    for (int c = 0; c < WIDTH; c++) pv[c*DW +: DW] = 16'(3 * c);
    preload(10'h040, 16'd3);
    expect_tile(16'h00F0, 10'h040, pv, 16'd3, lat);
    pulse_start(sc);
    wait_done(sc, lat, "t5");

    // 6: start ignored mid-tile and in FIN, accepted in the cycle after FIN
    for (int c = 0; c < WIDTH; c++) pv[c*DW +: DW] = 16'(16'h0040 + c);
    preload(10'h200, 16'h0100);
    expect_tile(16'h0000, 10'h000, pv, 16'h0000, lat);
    lc0 = load_cnt;
    pulse_start(sc);
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 100 && cyc < sc + lat; i++) begin
      @(posedge clk); #1;
    end
    check_val("t6_in_fin", 32'(bus.tile_done), 32'd1);
    bus.start = 1'b1;
    expect_tile(16'h0003, 10'h200, pv, 16'h0100, lat);
    sc2 = cyc + 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check_val("t6_loads", 32'(load_cnt), 32'(lc0 + 2));
    wait_done(sc2, lat, "t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
